// File: rtl/spi_ram_master.sv
// spi_ram_master: parallel-command SPI master for the single-port-RAM SPI slave (shared clk).
// Optional build macro SPI_RAM_MASTER_SEQ_CHK_EN adds command-sequence checking on seq_err.
module spi_ram_master #(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
    output logic       seq_err,
`endif
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEL   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] TURN  = 3'd3;
    localparam logic [2:0] RECV  = 3'd4;
    localparam logic [2:0] END   = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cmd_q;
    logic [9:0]       sr;
    logic [6:0]       rx_sr;
    logic             accept;

`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
    logic [1:0] last_cmd;
    logic       seq_ok;

    // wr-data must follow an address or data write; rd-data must follow a read address
    always_comb begin
        seq_ok = 1'b1;
        if (cmd == 2'b01)
            seq_ok = (last_cmd == 2'b00) || (last_cmd == 2'b01);
        else if (cmd == 2'b11)
            seq_ok = (last_cmd == 2'b10);
    end

    assign accept = start && (state == IDLE) && seq_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cmd <= 2'b11;
            seq_err  <= 1'b0;
        end else begin
            seq_err <= start && (state == IDLE) && !seq_ok;
            if (state == END)
                last_cmd <= cmd_q;
        end
    end
`else
    assign accept = start && (state == IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cmd_q <= '0;
            sr    <= '0;
            rx_sr <= '0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q <= cmd;
                        sr    <= {cmd, wdata};
                        cnt   <= '0;
                        state <= SEL;
                    end
                end
                SEL: state <= SHIFT;
                SHIFT: begin
                    sr <= {sr[8:0], 1'b0};
                    if (cnt == CNT_W'(9)) begin
                        cnt   <= '0;
                        state <= (cmd_q == 2'b11) ? TURN : END;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TURN: begin
                    if (cnt == CNT_W'(TURNAROUND - 1)) begin
                        cnt   <= '0;
                        state <= RECV;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RECV: begin
                    rx_sr <= {rx_sr[5:0], MISO};
                    // last bit goes straight into rdata so it never holds a partial byte
                    if (cnt == CNT_W'(7)) begin
                        rdata <= {rx_sr, MISO};
                        cnt   <= '0;
                        state <= END;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // SEL shows cmd[1] without shifting, so SHIFT starts again from the register MSB
    assign MOSI  = ((state == SEL) || (state == SHIFT)) ? sr[9] : 1'b0;
    assign SS_n  = !((state == SEL) || (state == SHIFT) || (state == TURN) || (state == RECV));
    assign ready = (state == IDLE);
    assign done  = (state == END);

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: directed self-checking bench for spi_ram_master (TURNAROUND=2).
// Also covers the SPI_RAM_MASTER_SEQ_CHK_EN build when that macro is defined.
module tb_spi_ram_master;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic [7:0] rdata;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
    logic       seq_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  exp_rdata = 8'h00;

    spi_ram_master #(.TURNAROUND(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cmd   (cmd),
        .wdata (wdata),
        .ready (ready),
        .done  (done),
        .rdata (rdata),
`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
        .seq_err (seq_err),
`endif
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame; cycle T+k is observed #1 after the k-th edge following accept edge T.
    task automatic do_frame(input string tag, input logic [1:0] c, input logic [7:0] d,
                            input logic [7:0] rx, input bit perturb);
        logic [10:0] exp_mosi;
        logic [10:0] got_mosi;
        int unsigned len;
        int unsigned ss_low;
        int unsigned done_at;
        int unsigned done_cnt;
        int unsigned ready_busy;
        exp_mosi   = {c[1], c, d};
        got_mosi   = '0;
        len        = (c == 2'b11) ? 22 : 12;
        ss_low     = 0;
        done_at    = 0;
        done_cnt   = 0;
        ready_busy = 0;
        @(negedge clk);
        start = 1'b1; cmd = c; wdata = d;
        @(posedge clk); #1;
        start = 1'b0; cmd = ~c; wdata = ~d;
`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
        check({tag, "_seq_err"}, 32'(seq_err), 0);
`endif
        for (int k = 1; k <= 30; k++) begin
            if (k <= 11) got_mosi[11-k] = MOSI;
            if (!SS_n) ss_low++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (ready && k <= len) ready_busy++;
            start = (perturb && k == 5) ? 1'b1 : 1'b0;
            if (perturb && k == 5) begin cmd = 2'b10; wdata = 8'hFF; end
            MISO = (c == 2'b11 && k >= 14 && k <= 21) ? rx[21-k] : 1'b0;
            @(posedge clk); #1;
        end
        MISO = 1'b0;
        if (c == 2'b11) exp_rdata = rx;
        check({tag, "_mosi"},   32'(got_mosi), 32'(exp_mosi));
        check({tag, "_done_at"}, done_at, len);
        check({tag, "_done_n"}, done_cnt, 1);
        check({tag, "_ss_low"}, ss_low, len - 1);
        check({tag, "_busy"},   ready_busy, 0);
        check({tag, "_rdata"},  32'(rdata), 32'(exp_rdata));
    endtask

    initial begin
        logic [25:0] ss_v, done_v, rdy_v, ss_e, done_e, rdy_e;
        int unsigned dcnt;
        rst_n = 1'b0; start = 1'b0; cmd = 2'b00; wdata = 8'h00; MISO = 1'b0;
        #2;
        check("rst_ss_n",  32'(SS_n),  1);
        check("rst_mosi",  32'(MOSI),  0);
        check("rst_ready", 32'(ready), 1);
        check("rst_done",  32'(done),  0);
        check("rst_rdata", 32'(rdata), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

`ifdef SPI_RAM_MASTER_SEQ_CHK_EN
        @(negedge clk);
        start = 1'b1; cmd = 2'b11; wdata = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        check("rej_seq_err", 32'(seq_err), 1);
        check("rej_ss_n",    32'(SS_n),    1);
        check("rej_ready",   32'(ready),   1);
        @(posedge clk); #1;
        check("rej_seq_clr", 32'(seq_err), 0);
        check("rej_ss_n2",   32'(SS_n),    1);
`endif

        do_frame("wr_addr", 2'b00, 8'h3C, 8'h00, 1'b0);
        do_frame("busy",    2'b01, 8'hC3, 8'h00, 1'b1);
        do_frame("rd_addr", 2'b10, 8'h3C, 8'h00, 1'b0);
        do_frame("rd_data", 2'b11, 8'h00, 8'hA5, 1'b0);

        // start held high: 13-cycle frame period (SEL..END, then one IDLE)
        @(negedge clk);
        start = 1'b1; cmd = 2'b00; wdata = 8'hFF;
        @(posedge clk); #1;
        for (int k = 1; k <= 26; k++) begin
            int unsigned pos;
            pos = ((k - 1) % 13) + 1;
            ss_v[k-1]   = SS_n;
            done_v[k-1] = done;
            rdy_v[k-1]  = ready;
            ss_e[k-1]   = (pos >= 12);
            done_e[k-1] = (pos == 12);
            rdy_e[k-1]  = (pos == 13);
            if (k == 26) start = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b_ss_n",  32'(ss_v),   32'(ss_e));
        check("b2b_done",  32'(done_v), 32'(done_e));
        check("b2b_ready", 32'(rdy_v),  32'(rdy_e));

        do_frame("rd_addr2", 2'b10, 8'h81, 8'h00, 1'b0);

        // reset asserted mid-RECV
        @(negedge clk);
        start = 1'b1; cmd = 2'b11; wdata = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        MISO = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        check("mid_ss_low", 32'(SS_n), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n",  32'(SS_n),  1);
        check("mid_rst_rdata", 32'(rdata), 0);
        check("mid_rst_ready", 32'(ready), 1);
        exp_rdata = 8'h00;
        MISO = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) rst_n = 1'b1;
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("mid_rst_no_done", dcnt, 0);

        do_frame("post_wr",  2'b00, 8'h5A, 8'h00, 1'b0);
        do_frame("post_ra",  2'b10, 8'h00, 8'h00, 1'b0);
        do_frame("post_rd",  2'b11, 8'h00, 8'h5A, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- Host-side SPI master that drives the single-port-RAM SPI slave subsystem (SS_n, MOSI, MISO) from a simple parallel command interface.
- SCLK is not a separate pin: the slave runs on the shared system clock `clk`, so the master drives SS_n and MOSI synchronously on `clk` and samples MISO on `clk`.
- Issues the four RAM frame types: write address (00), write data (01), read address (10) and read data (11).
- For read-data frames, it collects the 8-bit byte the slave returns.

Parameters:
- TURNAROUND, 2: idle `clk` cycles between the last MOSI bit and the first MISO sample, read-data frames only. Range 1..15.
- CNT_W, 4: width of the internal bit/turnaround counter.

Ports:
- clk  in  1  system clock, shared with the slave; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; accepted only when ready=1.
- cmd  in  2  frame type, captured at accept: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- wdata  in  8  payload, captured at accept (ignored/don't-care bits still shifted for cmd 11).
- ready  out  1  1 in IDLE only.
- done  out  1  one-cycle pulse at frame end.
- rdata  out  8  last byte received; updated only by cmd 11 frames.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, SS_n=1, MOSI=0, ready=1, done=0, rdata=8'h00, counters=0, captured cmd/wdata=0.
- FSM states: IDLE, SEL, SHIFT, TURN, RECV, END.
- IDLE: SS_n=1, MOSI=0, ready=1.
  - If start=1 at edge T: latch shift register {cmd, wdata} (10 bits), go to SEL.
- SEL (cycle T+1): SS_n=0, MOSI=cmd[1] (write/read select bit), 1 cycle, then SHIFT.
- SHIFT (T+2..T+11): SS_n=0; MOSI = shift register MSB first (cmd[1], cmd[0], wdata[7]..wdata[0]); exactly 10 cycles.
  - Next state: TURN if cmd=11, else END.
- TURN: SS_n=0, MOSI=0, exactly TURNAROUND cycles, then RECV.
- RECV: SS_n=0, MOSI=0; sample MISO on each of 8 rising edges into a shift register, MSB first; then END.
  - rdata loads the full byte on entry to END, never partially.
- END: SS_n=1, MOSI=0, done=1 for exactly this cycle; ready=0; next state IDLE.
  - Guarantees at least 2 cycles of SS_n high between frames (END plus IDLE).
- Latency from accept edge T:
  - Write and read-address frames: done at T+12.
  - Read-data frames: done at T+12+TURNAROUND+8 (T+22 at default).
- ready=0 from T+1 until the frame returns to IDLE; start while ready=0 is ignored, not queued.
- cmd/wdata changes after accept have no effect on the frame in flight.
- Reset asserted mid-frame: SS_n returns high immediately (asynchronous), no done pulse, rdata returns to 00.
- No command sequencing is enforced in the base build.

Optional Feature:
- Macro SPI_RAM_MASTER_SEQ_CHK_EN.
- Defined:
  - Adds output seq_err (1 bit, reset 0) and a 2-bit last-cmd register (reset 11).
  - A start with cmd=01 whose previous completed frame was not 00 or 01 is rejected: no frame issued, seq_err=1 for one cycle, ready stays 1.
  - Same rule for cmd=11 unless the previous frame was 10.
  - Rejected requests do not update last-cmd.
- Undefined: no seq_err port, all commands are accepted unconditionally.

Test Plan:
- Write address: start with cmd=00, wdata=8'h3C → SS_n low T+1..T+11, MOSI sequence 0,0,0,0,0,1,1,1,1,0,0; done at T+12; rdata unchanged (00).
- Read data: cmd=10 with wdata=8'h3C, then cmd=11; slave model drives 8'hA5 MSB first starting TURNAROUND cycles after the last MOSI bit → rdata=8'hA5 and done at T+22 (TURNAROUND=2).
- Back-to-back: start held high continuously → frames separated by ≥2 SS_n-high cycles; no start is accepted while ready=0.
- Busy ignore: change cmd/wdata and pulse start at T+5 → in-flight MOSI sequence unchanged; no second frame issued.
- Reset mid-frame: rst_n low during RECV → SS_n=1 and rdata=00 asynchronously; no done pulse; after release, the next start produces a correct frame.
- With SPI_RAM_MASTER_SEQ_CHK_EN: cmd=11 immediately after reset → seq_err pulse, SS_n stays 1; after a cmd=10 frame, cmd=11 is accepted with seq_err=0.
